// File: rtl/channel_broadcast.sv
// channel_broadcast: expands one value per channel into FRAME_LEN repeated beats per channel
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    start      begin a frame (sampled in IDLE only)
//    data_in    per-channel signed value, with valid_in / ready_in handshake
//    data_out   broadcast sample (optionally arithmetic-shifted), with valid_out / ready_out handshake
//    busy       high while loading or emitting
//    done       one-cycle pulse after the last beat of a frame
module channel_broadcast #(
   parameter int DATA_WIDTH  = 16,
   parameter int CHANNELS    = 16,
   parameter int FRAME_LEN   = 4,
   parameter int SCALE_SHIFT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic                  busy,
   output logic                  done
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int PW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
   state_t                        state_q;
   logic [CW-1:0]                 ld_cnt_q;
   logic [CW-1:0]                 ch_cnt_q;
   logic [PW-1:0]                 pos_cnt_q;
   logic signed [DATA_WIDTH-1:0]  buf_q [CHANNELS];
   logic                          ld_last;
   logic                          ch_last;
   logic                          pos_last;
   assign ld_last  = ld_cnt_q == CH_LAST;
   assign ch_last  = ch_cnt_q == CH_LAST;
   assign pos_last = pos_cnt_q == POS_LAST;
   // Outputs are pure decodes of state and buffer registers; ready_out never reaches an output.
   assign ready_in  = state_q == LOAD;
   assign valid_out = state_q == EMIT;
   assign busy      = ready_in | valid_out;
   assign done      = state_q == DONE;
   assign data_out  = valid_out ? DATA_WIDTH'(buf_q[ch_cnt_q] >>> SCALE_SHIFT) : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ld_cnt_q  <= '0;
         ch_cnt_q  <= '0;
         pos_cnt_q <= '0;
         for (int i = 0; i < CHANNELS; i++) buf_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q   <= LOAD;
               ld_cnt_q  <= '0;
               ch_cnt_q  <= '0;
               pos_cnt_q <= '0;
            end
            LOAD: if (valid_in) begin
               buf_q[ld_cnt_q] <= data_in;
               // Counters wrap to 0 so they never index past the buffer for non-power-of-2 sizes.
               ld_cnt_q        <= ld_last ? '0 : ld_cnt_q + 1'b1;
               if (ld_last) state_q <= EMIT;
            end
            EMIT: if (ready_out) begin
               pos_cnt_q <= pos_last ? '0 : pos_cnt_q + 1'b1;
               if (pos_last) ch_cnt_q <= ch_last ? '0 : ch_cnt_q + 1'b1;
               if (pos_last && ch_last) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_channel_broadcast.sv
// tb_channel_broadcast: directed checks of broadcast, stalls, shift, start filtering, reset and degenerate sizes
module tb_channel_broadcast;
   logic clk = 0;
   logic rst = 1;
   int tests = 0;
   int fails = 0;
   logic        a_start = 0, a_vin = 0, a_rin, a_vout, a_rout = 0, a_busy, a_done;
   logic [15:0] a_din = 0, a_dout;
   logic        b_start = 0, b_vin = 0, b_rin, b_vout, b_rout = 0, b_busy, b_done;
   logic [15:0] b_din = 0, b_dout;
   logic        c_start = 0, c_vin = 0, c_rin, c_vout, c_rout = 0, c_busy, c_done;
   logic [15:0] c_din = 0, c_dout;
   logic [15:0] va [4];
   logic [15:0] vb [4];
   logic [15:0] eb [4];
   always #5 clk = ~clk;
   channel_broadcast #(.DATA_WIDTH(16), .CHANNELS(4), .FRAME_LEN(4), .SCALE_SHIFT(0)) ua (
      .clk(clk), .rst(rst), .start(a_start), .data_in(a_din), .valid_in(a_vin), .ready_in(a_rin),
      .data_out(a_dout), .valid_out(a_vout), .ready_out(a_rout), .busy(a_busy), .done(a_done));
   channel_broadcast #(.DATA_WIDTH(16), .CHANNELS(4), .FRAME_LEN(4), .SCALE_SHIFT(2)) ub (
      .clk(clk), .rst(rst), .start(b_start), .data_in(b_din), .valid_in(b_vin), .ready_in(b_rin),
      .data_out(b_dout), .valid_out(b_vout), .ready_out(b_rout), .busy(b_busy), .done(b_done));
   channel_broadcast #(.DATA_WIDTH(16), .CHANNELS(1), .FRAME_LEN(1), .SCALE_SHIFT(0)) uc (
      .clk(clk), .rst(rst), .start(c_start), .data_in(c_din), .valid_in(c_vin), .ready_in(c_rin),
      .data_out(c_dout), .valid_out(c_vout), .ready_out(c_rout), .busy(c_busy), .done(c_done));
   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({a_rin, a_vout, a_busy, a_done, b_vout, b_busy, c_vout, c_busy} !== 8'h00 || a_dout !== 16'h0) begin
         fails++;
         $display("FAIL reset: got rin/vout/busy/done=%b%b%b%b dout=%h b/c vout,busy=%b%b%b%b exp all 0",
                  a_rin, a_vout, a_busy, a_done, a_dout, b_vout, b_busy, c_vout, c_busy);
      end
      rst = 0;
      @(negedge clk);
   endtask
   // One frame on instance A from IDLE; starts and ends at a negedge.
   task automatic frame_a(input int gap, input bit stall, input bit hammer, input bit done_start, input string nm);
      int beat = 0;
      int c = 0;
      int nin = 0;
      int nout = 0;
      a_start = 1;
      @(negedge clk);
      a_start = hammer;
      tests++;
      if (a_rin !== 1'b1 || a_busy !== 1'b1) begin
         fails++;
         $display("FAIL %s_load_entry: got rin=%b busy=%b exp 1 1", nm, a_rin, a_busy);
      end
      for (int i = 0; i < 4; i++) begin
         repeat (gap) begin
            a_vin = 0;
            @(negedge clk);
            tests++;
            if (a_rin !== 1'b1 || a_vout !== 1'b0) begin
               fails++;
               $display("FAIL %s_gap: got rin=%b vout=%b exp 1 0", nm, a_rin, a_vout);
            end
         end
         a_vin = 1;
         a_din = va[i];
         if (a_rin) nin++;
         @(negedge clk);
      end
      a_vin = 0;
      while (beat < 16 && c < 200) begin
         a_rout = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
         tests++;
         if (a_vout !== 1'b1 || a_dout !== va[beat / 4] || a_rin !== 1'b0 || a_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_beat%0d: got vout=%b dout=%h rin=%b busy=%b exp 1 %h 0 1",
                     nm, beat, a_vout, a_dout, a_rin, a_busy, va[beat / 4]);
         end
         if (a_vout && a_rout) begin
            beat++;
            nout++;
         end
         c++;
         @(negedge clk);
      end
      tests++;
      if (nin != 4 || nout != 16 || (!stall && c != 16)) begin
         fails++;
         $display("FAIL %s_count: got in=%0d out=%0d cycles=%0d exp 4 16 %0d", nm, nin, nout, c, stall ? c : 16);
      end
      a_start = done_start;
      tests++;
      if (a_done !== 1'b1 || a_vout !== 1'b0 || a_busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_done: got done=%b vout=%b busy=%b exp 1 0 0", nm, a_done, a_vout, a_busy);
      end
      @(negedge clk);
      a_start = 0;
      a_rout = 0;
      tests++;
      if (a_done !== 1'b0 || a_busy !== 1'b0 || a_rin !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle: got done=%b busy=%b rin=%b exp 0 0 0", nm, a_done, a_busy, a_rin);
      end
   endtask
   task automatic test_broadcast();
      va = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000};
      frame_a(0, 0, 0, 0, "bcast");
   endtask
   task automatic test_stall();
      frame_a(2, 1, 0, 0, "stall");
   endtask
   task automatic test_start_ignore();
      va = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      frame_a(0, 0, 1, 1, "hammer");
      va = '{16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0};
      frame_a(0, 0, 0, 0, "after_done");
   endtask
   task automatic test_shift();
      vb = '{16'h0100, 16'hFF00, 16'h8000, 16'hFFFD};
      eb = '{16'h0040, 16'hFFC0, 16'hE000, 16'hFFFF};
      b_start = 1;
      @(negedge clk);
      b_start = 0;
      for (int i = 0; i < 4; i++) begin
         b_vin = 1;
         b_din = vb[i];
         @(negedge clk);
      end
      b_vin = 0;
      b_rout = 1;
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (b_vout !== 1'b1 || b_dout !== eb[k / 4]) begin
            fails++;
            $display("FAIL shift_beat%0d: got vout=%b dout=%h exp 1 %h", k, b_vout, b_dout, eb[k / 4]);
         end
         @(negedge clk);
      end
      tests++;
      if (b_done !== 1'b1 || b_vout !== 1'b0) begin
         fails++;
         $display("FAIL shift_done: got done=%b vout=%b exp 1 0", b_done, b_vout);
      end
      @(negedge clk);
      b_rout = 0;
   endtask
   task automatic test_reset_mid();
      va = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};
      a_start = 1;
      @(negedge clk);
      a_start = 0;
      for (int i = 0; i < 4; i++) begin
         a_vin = 1;
         a_din = va[i];
         @(negedge clk);
      end
      a_vin = 0;
      a_rout = 1;
      repeat (7) @(negedge clk);
      tests++;
      if (a_vout !== 1'b1 || a_dout !== 16'h2468) begin
         fails++;
         $display("FAIL rstmid_beat7: got vout=%b dout=%h exp 1 2468", a_vout, a_dout);
      end
      #2 rst = 1;
      #1;
      tests++;
      if (a_vout !== 1'b0 || a_busy !== 1'b0 || a_dout !== 16'h0 || a_done !== 1'b0 || a_rin !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_async: got vout=%b busy=%b dout=%h done=%b rin=%b exp 0 0 0000 0 0",
                  a_vout, a_busy, a_dout, a_done, a_rin);
      end
      @(negedge clk);
      rst = 0;
      a_rout = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (a_done !== 1'b0 || a_busy !== 1'b0 || a_vout !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_quiet%0d: got done=%b busy=%b vout=%b exp 0 0 0", k, a_done, a_busy, a_vout);
         end
      end
      va = '{16'h0001, 16'hFFFF, 16'h4000, 16'hC000};
      frame_a(0, 0, 0, 0, "post_rst");
   endtask
   task automatic test_degenerate();
      c_start = 1;
      @(negedge clk);
      c_start = 0;
      c_vin = 1;
      c_din = 16'h1234;
      @(negedge clk);
      c_vin = 0;
      c_rout = 1;
      tests++;
      if (c_vout !== 1'b1 || c_dout !== 16'h1234 || c_rin !== 1'b0) begin
         fails++;
         $display("FAIL degen_beat: got vout=%b dout=%h rin=%b exp 1 1234 0", c_vout, c_dout, c_rin);
      end
      @(negedge clk);
      tests++;
      if (c_done !== 1'b1 || c_vout !== 1'b0) begin
         fails++;
         $display("FAIL degen_done: got done=%b vout=%b exp 1 0", c_done, c_vout);
      end
      @(negedge clk);
      c_rout = 0;
      tests++;
      if (c_done !== 1'b0 || c_busy !== 1'b0) begin
         fails++;
         $display("FAIL degen_idle: got done=%b busy=%b exp 0 0", c_done, c_busy);
      end
   endtask
   initial begin
      test_reset();
      test_broadcast();
      test_stall();
      test_shift();
      test_start_ignore();
      test_reset_mid();
      test_degenerate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/channel_broadcast.md
Name: channel_broadcast

Overview:
Global-pool inverse / broadcast stage. Accepts one Q8.8 value per channel (stream sum_ch0, sum_ch1, ...) and expands it back across the spatial dimension, emitting ch0[0..FRAME_LEN-1], ch1[0..FRAME_LEN-1], ... in the same stream order the pooling stage consumes. Used for the gradient/upsample path after global sum or average pooling in the ofdmGAN datapath. An optional arithmetic right shift turns it into the average-pool inverse.

Parameters:
DATA_WIDTH, 16, sample width, Q8.8 signed
CHANNELS, 16, values loaded per frame (one per channel)
FRAME_LEN, 4, output repeats per channel
SCALE_SHIFT, 0, arithmetic right shift applied on output (0 = pure broadcast; $clog2(FRAME_LEN) = avg-pool inverse)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a frame; sampled in IDLE only
data_in  in  DATA_WIDTH  signed per-channel value
valid_in  in  1  data_in valid
ready_in  out  1  block accepts data_in
data_out  out  DATA_WIDTH  signed broadcast sample
valid_out  out  1  data_out valid
ready_out  in  1  downstream accepts data_out
busy  out  1  high in LOAD or EMIT
done  out  1  one-cycle pulse at end of frame

Behaviour:
- One clock, clk; rst asynchronous, active-high. On rst: state=IDLE, all counters 0, channel buffer cleared to 0. Outputs under reset: ready_in=0, valid_out=0, data_out=0, busy=0, done=0.
- Storage: CHANNELS x DATA_WIDTH register buffer. Counters: ld_cnt (0..CHANNELS-1), ch_cnt (0..CHANNELS-1), pos_cnt (0..FRAME_LEN-1). Each counter is max(1,$clog2(N)) bits wide.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start=1 -> LOAD; ld_cnt, ch_cnt and pos_cnt cleared.
  - start asserted in any other state is ignored.
- LOAD:
  - ready_in=1.
  - Handshake (valid_in & ready_in) writes buf[ld_cnt]<=data_in and increments ld_cnt.
  - Handshake with ld_cnt==CHANNELS-1 -> EMIT.
  - valid_in gaps are allowed and stall the load without side effects.
- EMIT:
  - valid_out=1 and data_out = buf[ch_cnt] >>> SCALE_SHIFT (arithmetic shift, floor, no rounding, no saturation).
  - valid_out and data_out are decoded from registers only. There is no combinational path from ready_out to any output.
  - Handshake (valid_out & ready_out) advances pos_cnt. At pos_cnt==FRAME_LEN-1, pos_cnt wraps to 0 and ch_cnt increments.
  - Handshake with ch_cnt==CHANNELS-1 and pos_cnt==FRAME_LEN-1 -> DONE.
  - While ready_out=0, data_out is held stable and valid_out stays high (AXI-style: valid never drops without a handshake).
- DONE: done=1 for exactly one cycle, valid_out=0, then -> IDLE. A start in this cycle is ignored.
- busy = (state==LOAD)|(state==EMIT). ready_in=0 outside LOAD.
- Latency:
  - First valid_out is high in the cycle after the final load handshake.
  - With ready_out held high, one beat per cycle: CHANNELS*FRAME_LEN consecutive beats, then done on the following cycle.
- Degenerate sizes:
  - FRAME_LEN=1: straight pass-through after buffering.
  - CHANNELS=1: a single load, then FRAME_LEN repeats.
- Reset mid-operation, in any state: immediate return to IDLE, buffer cleared, no done pulse. The next frame requires a new start.
- Buffer contents persist from DONE until the next start. Clearing at start is not required.

Test Plan:
- CHANNELS=4, FRAME_LEN=4, SHIFT=0; start, then load 0x0100, 0xFF00, 0x7FFF, 0x8000 back-to-back with ready_out=1 -> 16 consecutive beats: 4x0100, 4xFF00, 4x7FFF, 4x8000, first beat the cycle after the 4th load, done pulses 1 cycle after beat 16, busy falls with it.
- Same frame with ready_out toggling 1,0,0,1,... and valid_in gaps of 2 cycles -> no beat lost or duplicated, data_out constant while ready_out=0, ready_in low outside LOAD, total handshakes = 4 in and 16 out.
- SCALE_SHIFT=2, load 0x0100, 0xFF00, 0x8000, 0xFFFD -> outputs 0x0040, 0xFFC0, 0xE000, 0xFFFF, each repeated 4 times.
- Assert start during LOAD and during EMIT -> ignored, sequence unchanged. Assert start in the DONE cycle -> ignored; start one cycle later -> new frame proceeds normally.
- Assert rst at beat 7 of EMIT -> valid_out and busy drop asynchronously, no done pulse, buffer reads 0. A fresh frame afterwards produces correct output.
- CHANNELS=1, FRAME_LEN=1: load 0x1234 -> exactly one beat 0x1234, then done.
